// File: rtl/intr_port_feeder.sv
`timescale 1ns/1ps
// Purpose: queues 8-bit producer events and presents each one to the processor input port, then raises its interrupt.
// Latency: an event pushed into an empty FIFO at edge N is popped at N+1 and intr_out rises at N+2; ack at edge M gives the next pop at M+1.
// Backpressure: ev_ready = !full; a push while full is dropped and sets sticky overflow; a pop never raises ev_ready in the same cycle.
// Ports: clk/rst_n (async active-low); ev_valid/ev_data/ev_ready producer handshake;
//        port_out_pins from processor OUTPUT_PORT_PINS (ack source); port_in_data to INPUT_PORT_PINS;
//        intr_out to INTR_IN; overflow sticky drop flag; pending = FIFO occupancy + held event.
module intr_port_feeder #(
  parameter int          DEPTH        = 4,
  parameter int          PULSE_CYCLES = 3,
  parameter int          TIMEOUT      = 255,
  parameter logic [7:0]  ACK_CODE     = 8'hAC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  input  logic [7:0] ev_data,
  output logic       ev_ready,
  input  logic [7:0] port_out_pins,
  output logic [7:0] port_in_data,
  output logic       intr_out,
  output logic       overflow,
  output logic [4:0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, PULSE, WAIT_ACK} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      out_q;
  logic [3:0]      pulse_cnt;
  logic [7:0]      to_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic ack;
  logic busy;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign ev_ready = !full;
  assign push     = ev_valid && !full;
  // Pop only from IDLE, so a freshly pushed entry is seen one edge later.
  assign pop      = (state == IDLE) && !empty;
  // Ack is an edge into ACK_CODE: the ISR must write something else before acking again.
  assign ack      = (port_out_pins == ACK_CODE) && (out_q != ACK_CODE);
  assign busy     = (state != IDLE);
  assign pending  = 5'(count) + {4'd0, busy};

  // Storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      out_q    <= 8'd0;
    end else begin
      out_q <= port_out_pins;
      if (ev_valid && !ev_ready) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      port_in_data <= 8'd0;
      intr_out     <= 1'b0;
      pulse_cnt    <= 4'd0;
      to_cnt       <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            port_in_data <= mem[rd_ptr];
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          // Setup cycle: data has been stable for one clock before the interrupt rises.
          pulse_cnt <= 4'(PULSE_CYCLES);
          intr_out  <= 1'b1;
          state     <= PULSE;
        end
        PULSE: begin
          if (ack) begin
            intr_out <= 1'b0;
            state    <= IDLE;
          end else if (pulse_cnt == 4'd1) begin
            intr_out <= 1'b0;
            to_cnt   <= 8'(TIMEOUT);
            state    <= WAIT_ACK;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            state <= IDLE;
          end else if (to_cnt == 8'd1) begin
            // Retry with the same held data; there is no retry limit.
            pulse_cnt <= 4'(PULSE_CYCLES);
            intr_out  <= 1'b1;
            state     <= PULSE;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_port_feeder.sv
`timescale 1ns/1ps
// Purpose: directed bench for intr_port_feeder with default parameters (DEPTH 4, pulse 3, timeout 255, ack 8'hAC).
// Latency: inputs are driven and outputs sampled on the falling edge, half a cycle away from the active edge.
// Backpressure: the streaming section only asserts ev_valid while ev_ready is high; the overflow section does not.
module tb_intr_port_feeder;

  logic       clk;
  logic       rst_n;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic       ev_ready;
  logic [7:0] port_out_pins;
  logic [7:0] port_in_data;
  logic       intr_out;
  logic       overflow;
  logic [4:0] pending;

  int checks;
  int failures;

  intr_port_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ev_valid      (ev_valid),
    .ev_data       (ev_data),
    .ev_ready      (ev_ready),
    .port_out_pins (port_out_pins),
    .port_in_data  (port_in_data),
    .intr_out      (intr_out),
    .overflow      (overflow),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hi;
    int lo;
    int acc;
    int sent;
    int got;
    int cyc;
    int max_pend;
    bit acking;
    logic [7:0] nxt;
    logic [7:0] exp_q[$];

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ev_valid = 1'b0;
    ev_data = 8'd0;
    port_out_pins = 8'd0;

    // Reset values
    @(negedge clk);
    tick();
    chk("rst_port_in_data", port_in_data, 8'h00);
    chk("rst_intr_out", intr_out, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_pending", pending, 5'd0);
    chk("rst_ev_ready", ev_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single event with early ack two cycles into the pulse
    ev_valid = 1'b1; ev_data = 8'h42;
    tick();                                   // edge N: push
    ev_valid = 1'b0;
    chk("n_pending", pending, 5'd1);
    chk("n_no_bypass", port_in_data, 8'h00);
    tick();                                   // N+1: pop
    chk("n1_data", port_in_data, 8'h42);
    chk("n1_intr_low", intr_out, 1'b0);
    chk("n1_pending", pending, 5'd1);
    tick();                                   // N+2: pulse starts
    chk("n2_intr_high", intr_out, 1'b1);
    tick();
    chk("n3_intr_high", intr_out, 1'b1);
    port_out_pins = 8'hAC;
    tick();                                   // ack edge
    chk("ack_intr_low", intr_out, 1'b0);
    chk("ack_pending", pending, 5'd0);
    chk("ack_data_held", port_in_data, 8'h42);
    port_out_pins = 8'h00;
    tick();

    // Three events, no ack: 3 high, 255 low, retry with same data
    ev_valid = 1'b1; ev_data = 8'h11; tick();
    ev_data = 8'h22; tick();
    ev_data = 8'h33; tick();
    ev_valid = 1'b0;
    hi = 0;
    while (intr_out && hi < 20) begin hi++; tick(); end
    chk("pulse_len", hi, 3);
    lo = 0;
    while (!intr_out && lo < 400) begin lo++; tick(); end
    chk("timeout_gap", lo, 255);
    chk("retry_intr", intr_out, 1'b1);
    chk("retry_data", port_in_data, 8'h11);
    chk("retry_pending", pending, 5'd3);
    port_out_pins = 8'hAC;
    tick();                                   // M: ack
    chk("m_intr_low", intr_out, 1'b0);
    chk("m_pending", pending, 5'd2);
    tick();                                   // M+1: pop 22
    chk("m1_data", port_in_data, 8'h22);
    tick();                                   // M+2: rise
    chk("m2_intr_high", intr_out, 1'b1);
    // AC still held: no fresh transition, so no ack for 22
    tick(); tick(); tick();
    chk("held_ac_no_ack_intr", intr_out, 1'b0);
    chk("held_ac_no_ack_pend", pending, 5'd2);
    chk("held_ac_data", port_in_data, 8'h22);
    port_out_pins = 8'h00; tick();
    port_out_pins = 8'hAC; tick();            // fresh ack
    chk("reack_pending", pending, 5'd1);
    port_out_pins = 8'h00; tick();            // pop 33 into PRESENT
    chk("pop33_data", port_in_data, 8'h33);
    port_out_pins = 8'hAC; tick();            // ack edge during PRESENT: ignored
    chk("present_ack_ignored", intr_out, 1'b1);
    tick(); tick(); tick();
    chk("present_ack_pend", pending, 5'd1);
    chk("present_ack_intr", intr_out, 1'b0);
    port_out_pins = 8'h00; tick();
    port_out_pins = 8'hAC; tick();
    chk("drain_pending", pending, 5'd0);
    port_out_pins = 8'h00; tick();

    // Hold ev_valid for six attempts with no ack
    chk("pre_overflow", overflow, 1'b0);
    acc = 0;
    nxt = 8'd1;
    for (int i = 0; i < 6; i++) begin
      ev_valid = 1'b1;
      ev_data = nxt;
      if (i == 5) chk("ready_low_6th", ev_ready, 1'b0);
      if (i == 5) chk("ovf_before_6th", overflow, 1'b0);
      if (ev_ready) begin acc++; nxt = nxt + 8'd1; end
      tick();
    end
    ev_valid = 1'b0;
    chk("accepts", acc, 5);
    chk("full_pending", pending, 5'd5);
    chk("full_ev_ready", ev_ready, 1'b0);
    chk("overflow_set", overflow, 1'b1);
    tick(); tick();
    chk("overflow_sticky", overflow, 1'b1);

    // Streaming through a full FIFO with ack-driven pops: order across pointer wrap
    for (int v = 1; v <= 5; v++) exp_q.push_back(8'(v));
    sent = 0; got = 0; cyc = 0; max_pend = 0; acking = 1'b0;
    while (got < 21 && cyc < 3000) begin
      if (sent < 16 && ev_ready) begin
        ev_valid = 1'b1;
        ev_data = 8'h10 + 8'(sent);
        exp_q.push_back(ev_data);
        sent++;
      end else begin
        ev_valid = 1'b0;
      end
      if (int'(pending) > max_pend) max_pend = int'(pending);
      if (intr_out && !acking) begin
        if (exp_q.size() > 0) chk("order", port_in_data, exp_q.pop_front());
        else chk("order_extra", port_in_data, 32'hFFFF_FFFF);
        got++;
        port_out_pins = 8'hAC;
        acking = 1'b1;
      end else if (!intr_out) begin
        port_out_pins = 8'h00;
        acking = 1'b0;
      end
      tick();
      cyc++;
    end
    ev_valid = 1'b0;
    port_out_pins = 8'h00;
    chk("stream_count", got, 21);
    chk("stream_sent", sent, 16);
    chk("stream_max_pending", max_pend, 5);
    tick(); tick();
    chk("stream_drained", pending, 5'd0);

    // Asynchronous reset in the middle of a pulse
    ev_valid = 1'b1; ev_data = 8'h55; tick();
    ev_data = 8'h66; tick();
    ev_valid = 1'b0;
    hi = 0;
    while (!intr_out && hi < 10) begin hi++; tick(); end
    chk("mid_pulse_intr", intr_out, 1'b1);
    chk("mid_pulse_pending", pending, 5'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_intr", intr_out, 1'b0);
    chk("arst_pending", pending, 5'd0);
    chk("arst_data", port_in_data, 8'h00);
    chk("arst_ready", ev_ready, 1'b1);
    chk("arst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_arst_pending", pending, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
